m_stopwatch_ctrl: RTL
=====================

Name: m_stopwatch_ctrl

Overview:
Control unit for the stopwatch counter datapath. It synchronizes and debounces the raw start/stop and lap/reset push buttons, and runs the start/stop/lap/clear state machine. It drives the counter's enable and clear. It also produces the display values, which are either the live BCD count or a frozen lap (split) snapshot. It sits between the board buttons and the min/sec/msec counter, in the same 100 Hz clock domain.

Parameters:
P_DEBOUNCE_CYCLES, 2, number of consecutive clk cycles a synchronized button level must stay stable before it is accepted; minimum 1.

Ports:
clk  input  1  system clock, 100 Hz nominal; all logic on posedge.
rst  input  1  asynchronous, active-low reset.
start_sw  input  1  raw start/stop button, active-high, asynchronous to clk.
lap_sw  input  1  raw lap/reset button, active-high, asynchronous to clk.
cnt_min  input  8  live BCD minutes from the counter datapath.
cnt_sec  input  8  live BCD seconds from the counter datapath.
cnt_msec  input  8  live BCD hundredths of a second from the counter datapath.
count_en  output  1  counter enable.
count_clr  output  1  single-cycle synchronous clear pulse to the counter.
disp_min  output  8  displayed BCD minutes.
disp_sec  output  8  displayed BCD seconds.
disp_msec  output  8  displayed BCD hundredths of a second.
run_led  output  1  high while the counter runs.
lap_led  output  1  high while the lap snapshot is displayed.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count_en, count_clr, run_led and lap_led are 0.
  - Lap hold registers are 0.
  - Synchronizer, debounce counters and debounced levels are 0.
- Input conditioning, identical per button:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level takes a new value only after the synchronized level has differed from it for P_DEBOUNCE_CYCLES consecutive cycles. Any shorter excursion resets the counter and is ignored.
  - Press event = one-cycle pulse on the debounced rising edge. One press per assertion; holding the button never repeats.
- Latency: raw input first sampled high at edge k and held → state and registered outputs change at edge k+2+P_DEBOUNCE_CYCLES (k+4 at default).
- A button held through reset release yields a press after the same latency.
- FSM, transitions on press events:
  - IDLE: start → RUN. lap → stay IDLE, pulse count_clr.
  - RUN: start → STOP. lap → LAP, capturing cnt_min/sec/msec into the hold registers at the same edge.
  - LAP: start → STOP (display reverts to live). lap → RUN (release hold, no new capture).
  - STOP: start → RUN. lap → IDLE with count_clr=1 for exactly one cycle (the edge entering IDLE through the next edge).
- Simultaneous start and lap press in the same cycle: start wins and lap is discarded (no capture, no clear).
- Outputs:
  - count_en = run_led = registered (state==RUN || state==LAP).
  - lap_led = registered (state==LAP).
  - count_clr is registered.
  - disp_* = hold registers when lap_led=1, otherwise cnt_* passed through combinationally (zero latency).
- Counting continues underneath a held lap display; the controller never modifies the BCD values themselves.
- Reset asserted mid-operation (any state): all outputs clear immediately, without waiting for clk; disp_* reverts to cnt_*.

Test Plan:
1. Hold rst=0, then release with buttons low → count_en=0, count_clr=0, run_led=0, lap_led=0; with cnt_sec=8'h42 driven, disp_sec=8'h42.
2. IDLE, start_sw high from edge k for 4 cycles (P=2) → count_en and run_led go 1 at edge k+4. A second identical press → STOP, count_en=0 at its edge+4.
3. Glitch rejection: start_sw high for 1 cycle, and separately high-low-high alternating per cycle → no state change, count_en stays 0.
4. RUN with cnt_min=8'h01, cnt_sec=8'h12, cnt_msec=8'h34 at the capture edge, lap press, then cnt_* changing every cycle:
   - disp_* stays 01/12/34; lap_led=1; count_en=1.
   - Second lap press → lap_led=0 and disp_* follows cnt_*.
5. RUN → start press → STOP, then lap press → count_clr high exactly one cycle, state IDLE, count_en=0. A further lap press in IDLE → another single-cycle count_clr.
6. Corner cases:
   - In RUN, start_sw and lap_sw rise on the same edge → STOP, lap_led=0, no capture.
   - In LAP, rst=0 asynchronously between edges → all outputs 0 before the next posedge.

Source files
------------

// File: rtl/m_stopwatch_ctrl.sv
// m_stopwatch_ctrl: stopwatch control unit.
//   Conditions the raw start/stop and lap/reset buttons (2-flop sync + debounce),
//   runs the IDLE/RUN/LAP/STOP state machine, drives counter enable/clear and
//   selects the displayed BCD value (live count or frozen lap snapshot).
// Ports:
//   clk, rst (async, active-low)
//   start_sw, lap_sw           raw active-high buttons, asynchronous to clk
//   cnt_min/cnt_sec/cnt_msec   live BCD count from the counter datapath
//   count_en, count_clr        counter enable and single-cycle clear
//   disp_min/disp_sec/disp_msec displayed BCD value
//   run_led, lap_led           status indicators

// Per-button conditioning: synchronizer, debounce counter, registered press pulse.
module m_stopwatch_ctrl_debounce #(
  parameter int unsigned P_DEBOUNCE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam int unsigned CW = (P_DEBOUNCE_CYCLES > 1) ? $clog2(P_DEBOUNCE_CYCLES) : 1;

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          level_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          accept_c;

  // The synchronized level has differed for the required number of cycles.
  assign accept_c = (sync_q != level_q) && (cnt_q == CW'(P_DEBOUNCE_CYCLES - 1));

  // Debounce next-state: any return to the accepted level restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync_q == level_q) begin
      cnt_d = '0;
    end else if (accept_c) begin
      level_d = sync_q;
      cnt_d   = '0;
      press_d = sync_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

module m_stopwatch_ctrl #(
  parameter int unsigned P_DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_sw,
  input  logic       lap_sw,
  input  logic [7:0] cnt_min,
  input  logic [7:0] cnt_sec,
  input  logic [7:0] cnt_msec,
  output logic       count_en,
  output logic       count_clr,
  output logic [7:0] disp_min,
  output logic [7:0] disp_sec,
  output logic [7:0] disp_msec,
  output logic       run_led,
  output logic       lap_led
);

  localparam int unsigned BCD_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAP  = 2'd2,
    S_STOP = 2'd3
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic             count_en_q;
  logic             count_en_d;
  logic             lap_led_q;
  logic             lap_led_d;
  logic             count_clr_q;
  logic             count_clr_d;
  logic [BCD_W-1:0] hold_min_q;
  logic [BCD_W-1:0] hold_min_d;
  logic [BCD_W-1:0] hold_sec_q;
  logic [BCD_W-1:0] hold_sec_d;
  logic [BCD_W-1:0] hold_msec_q;
  logic [BCD_W-1:0] hold_msec_d;
  logic             start_press;
  logic             lap_press;
  logic             lap_ev_c;

  m_stopwatch_ctrl_debounce #(
    .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (start_sw),
    .press_o(start_press)
  );

  m_stopwatch_ctrl_debounce #(
    .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
  ) u_db_lap (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (lap_sw),
    .press_o(lap_press)
  );

  // A start press in the same cycle swallows a lap press entirely.
  assign lap_ev_c = lap_press & ~start_press;

  // State register, registered outputs and lap hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_en_q  <= 1'b0;
      lap_led_q   <= 1'b0;
      count_clr_q <= 1'b0;
      hold_min_q  <= '0;
      hold_sec_q  <= '0;
      hold_msec_q <= '0;
    end else begin
      state_q     <= state_d;
      count_en_q  <= count_en_d;
      lap_led_q   <= lap_led_d;
      count_clr_q <= count_clr_d;
      hold_min_q  <= hold_min_d;
      hold_sec_q  <= hold_sec_d;
      hold_msec_q <= hold_msec_d;
    end
  end

  // Next state, next registered outputs and lap capture.
  always_comb begin
    state_d     = state_q;
    count_clr_d = 1'b0;
    hold_min_d  = hold_min_q;
    hold_sec_d  = hold_sec_q;
    hold_msec_d = hold_msec_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_press) begin
          state_d = S_RUN;
        end else if (lap_ev_c) begin
          count_clr_d = 1'b1;
        end
      end
      S_RUN: begin
        if (start_press) begin
          state_d = S_STOP;
        end else if (lap_ev_c) begin
          state_d     = S_LAP;
          hold_min_d  = cnt_min;
          hold_sec_d  = cnt_sec;
          hold_msec_d = cnt_msec;
        end
      end
      S_LAP: begin
        if (start_press) begin
          state_d = S_STOP;
        end else if (lap_ev_c) begin
          state_d = S_RUN;
        end
      end
      S_STOP: begin
        if (start_press) begin
          state_d = S_RUN;
        end else if (lap_ev_c) begin
          state_d     = S_IDLE;
          count_clr_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    count_en_d = (state_d == S_RUN) || (state_d == S_LAP);
    lap_led_d  = (state_d == S_LAP);
  end

  assign count_en  = count_en_q;
  assign run_led   = count_en_q;
  assign lap_led   = lap_led_q;
  assign count_clr = count_clr_q;

  // Live count passes straight through unless the lap snapshot is shown.
  assign disp_min  = lap_led_q ? hold_min_q  : cnt_min;
  assign disp_sec  = lap_led_q ? hold_sec_q  : cnt_sec;
  assign disp_msec = lap_led_q ? hold_msec_q : cnt_msec;

endmodule
